// File: rtl/pe_pkg.sv
// -----------------------------------------------------------------------------
// pe_pkg
// Shared types for the mono_PE MAC sequencer: FSM state encoding, PE byte
// width and the configuration bundle latched when a job is accepted.
// The cfg bundle field widths follow SEQ_CNT_W / SEQ_ADDR_W. The sequencer
// parameters default to these, so change both together.
// -----------------------------------------------------------------------------
package pe_pkg;

    localparam int PE_DATA_W  = 8;
    localparam int SEQ_CNT_W  = 8;
    localparam int SEQ_ADDR_W = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

    typedef struct packed {
        logic [SEQ_CNT_W-1:0]  k_len;
        logic [SEQ_CNT_W-1:0]  n_out;
        logic [SEQ_ADDR_W-1:0] ifm_base;
        logic [SEQ_ADDR_W-1:0] w_base;
    } seq_cfg_t;

endpackage

// File: rtl/pe_seq_addr_gen.sv
// -----------------------------------------------------------------------------
// pe_seq_addr_gen
// Inner (k) / outer (o) loop counters and buffer address generation.
// The weight address advances by one on every issue, because o*k_len + k is
// contiguous across outputs. A running offset therefore replaces the
// multiplier. Both addresses wrap modulo 2^ADDR_W.
//
// Ports:
//   clk, reset_n   clock, async active-low reset
//   init           zero the counters (accepted start)
//   adv            one read pair issued this cycle
//   k_len, n_out   latched job geometry
//   ifm_base       latched IFM base address
//   w_base         latched weight base address
//   ifm_addr       ifm_base + k
//   w_addr         w_base + running offset
//   o_idx          current output index
//   first, last    k == 0, k == k_len-1
//   job_last       last MAC of the last output
// -----------------------------------------------------------------------------
module pe_seq_addr_gen #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              init,
    input  logic              adv,
    input  logic [CNT_W-1:0]  k_len,
    input  logic [CNT_W-1:0]  n_out,
    input  logic [ADDR_W-1:0] ifm_base,
    input  logic [ADDR_W-1:0] w_base,
    output logic [ADDR_W-1:0] ifm_addr,
    output logic [ADDR_W-1:0] w_addr,
    output logic [CNT_W-1:0]  o_idx,
    output logic              first,
    output logic              last,
    output logic              job_last
);

    logic [CNT_W-1:0]  k_q;
    logic [CNT_W-1:0]  o_q;
    logic [ADDR_W-1:0] w_off_q;

    assign first    = (k_q == '0);
    assign last     = (k_q == k_len - CNT_W'(1));
    assign job_last = last && (o_q == n_out - CNT_W'(1));
    assign ifm_addr = ifm_base + ADDR_W'(k_q);
    assign w_addr   = w_base + w_off_q;
    assign o_idx    = o_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            k_q     <= '0;
            o_q     <= '0;
            w_off_q <= '0;
        end else if (init) begin
            k_q     <= '0;
            o_q     <= '0;
            w_off_q <= '0;
        end else if (adv) begin
            w_off_q <= w_off_q + ADDR_W'(1);
            if (last) begin
                k_q <= '0;
                o_q <= o_q + CNT_W'(1);
            end else begin
                k_q <= k_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pe_mac_sequencer.sv
// -----------------------------------------------------------------------------
// pe_mac_sequencer
// Upstream control for the mono_PE MAC element. For each job it streams
// k_len byte pairs per output, n_out outputs, from the IFM and weight buffers
// into the PE. It strobes PE_reset on the first MAC and PE_finish on the last
// MAC of each output, and tags each PE result with its output index.
//
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   start                        job request (accepted only in IDLE)
//   cfg_k_len, cfg_n_out         MACs per output, outputs per job
//   cfg_ifm_base, cfg_w_base     buffer base addresses
//   busy, done                   job in progress, one-cycle end pulse
//   ifm_rd_en/addr, w_rd_en/addr buffer reads (1-cycle latency)
//   ifm_rdata, w_rdata           buffer data
//   pe_ifm, pe_weight            pass-through of read data to the PE
//   pe_reset, pe_finish          PE accumulate framing strobes
//   pe_valid                     PE result valid
//   ofm_idx                      output index aligned with pe_valid
//   perf_cycles                  busy cycles of the last job (optional)
//
// Optional feature macro: PE_SEQ_PERF_CNT_EN adds perf_cycles.
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | one IFM/weight read pair per cycle
// DRAIN | reads done, waiting for the last PE result
// DONE  | one-cycle done pulse
// -----------------------------------------------------------------------------
module pe_mac_sequencer
    import pe_pkg::*;
#(
    parameter int ADDR_W = SEQ_ADDR_W,
    parameter int CNT_W  = SEQ_CNT_W,
    parameter int DATA_W = PE_DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  cfg_k_len,
    input  logic [CNT_W-1:0]  cfg_n_out,
    input  logic [ADDR_W-1:0] cfg_ifm_base,
    input  logic [ADDR_W-1:0] cfg_w_base,
    output logic              busy,
    output logic              done,
    output logic              ifm_rd_en,
    output logic              w_rd_en,
    output logic [ADDR_W-1:0] ifm_addr,
    output logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] ifm_rdata,
    input  logic [DATA_W-1:0] w_rdata,
    output logic [DATA_W-1:0] pe_ifm,
    output logic [DATA_W-1:0] pe_weight,
    output logic              pe_reset,
    output logic              pe_finish,
    input  logic              pe_valid,
`ifdef PE_SEQ_PERF_CNT_EN
    output logic [31:0]       perf_cycles,
`endif
    output logic [CNT_W-1:0]  ofm_idx
);

    seq_state_e       state_q, state_d;
    seq_cfg_t         cfg_q;
    logic             start_acc;
    logic             zero_job;
    logic             issue;
    logic             k_first, k_last, job_last;
    logic [CNT_W-1:0] o_cur, o_d1;
    logic [CNT_W-1:0] k_len_q, n_out_q;

    assign start_acc = start && (state_q == IDLE);
    assign zero_job  = (cfg_k_len == '0) || (cfg_n_out == '0);
    assign issue     = (state_q == ISSUE);
    assign k_len_q   = CNT_W'(cfg_q.k_len);
    assign n_out_q   = CNT_W'(cfg_q.n_out);

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign ifm_rd_en = issue;
    assign w_rd_en   = issue;
    assign pe_ifm    = ifm_rdata;
    assign pe_weight = w_rdata;

    pe_seq_addr_gen #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_addr_gen (
        .clk      (clk),
        .reset_n  (reset_n),
        .init     (start_acc),
        .adv      (issue),
        .k_len    (k_len_q),
        .n_out    (n_out_q),
        .ifm_base (ADDR_W'(cfg_q.ifm_base)),
        .w_base   (ADDR_W'(cfg_q.w_base)),
        .ifm_addr (ifm_addr),
        .w_addr   (w_addr),
        .o_idx    (o_cur),
        .first    (k_first),
        .last     (k_last),
        .job_last (job_last)
    );

    // Outputs are tagged in order, so the result carrying the final index
    // is the last one the job will produce.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_acc) state_d = zero_job ? DONE : ISSUE;
            ISSUE:   if (job_last) state_d = DRAIN;
            DRAIN:   if (pe_valid && (ofm_idx == n_out_q - CNT_W'(1))) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cfg_q   <= '0;
        end else begin
            state_q <= state_d;
            if (start_acc) begin
                cfg_q.k_len    <= SEQ_CNT_W'(cfg_k_len);
                cfg_q.n_out    <= SEQ_CNT_W'(cfg_n_out);
                cfg_q.ifm_base <= SEQ_ADDR_W'(cfg_ifm_base);
                cfg_q.w_base   <= SEQ_ADDR_W'(cfg_w_base);
            end
        end
    end

    // Strobes are delayed one cycle to meet the read data. The index is
    // delayed two cycles to meet the PE result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pe_reset  <= 1'b0;
            pe_finish <= 1'b0;
            o_d1      <= '0;
            ofm_idx   <= '0;
        end else begin
            pe_reset  <= issue && k_first;
            pe_finish <= issue && k_last;
            o_d1      <= o_cur;
            ofm_idx   <= o_d1;
        end
    end

`ifdef PE_SEQ_PERF_CNT_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_q <= '0;
        end else if (start_acc) begin
            perf_q <= '0;
        end else if (busy && (perf_q != '1)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule
